// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel plotter: screen geometry,
// clear-FSM states, the pixel record and linear address arithmetic.
package pixel_pkg;

   localparam int H_RES    = 160;
   localparam int V_RES    = 120;
   localparam int COLOR_W  = 3;
   localparam int ADDR_W   = 15;
   localparam int FB_WORDS = H_RES * V_RES;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      CLEAR = 2'd2,
      DONE  = 2'd3
   } plot_state_t;

   typedef struct packed {
      logic [7:0]         x;
      logic [6:0]         y;
      logic [COLOR_W-1:0] colour;
   } pixel_t;

   // y*160 + x as (y<<7) + (y<<5) + x on zero-extended operands, no multiplier
   function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x,
                                                    input logic [6:0] y);
      logic [ADDR_W-1:0] xe;
      logic [ADDR_W-1:0] ye;
      xe = {{(ADDR_W-8){1'b0}}, x};
      ye = {{(ADDR_W-7){1'b0}}, y};
      return (ye << 7) + (ye << 5) + xe;
   endfunction

endpackage

// File: rtl/clear_sweeper.sv
// Full-screen sweep counters for the clear operation. cx/cy walk the
// screen in raster order while ca tracks the matching linear address, so no
// address arithmetic is needed during the sweep. 'last' flags the final word.
module clear_sweeper #(
   parameter int H_RES  = 160,
   parameter int V_RES  = 120,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              en,
   output logic [7:0]        cx,
   output logic [6:0]        cy,
   output logic [ADDR_W-1:0] ca,
   output logic              last
);
   import pixel_pkg::*;

   localparam logic [7:0]        CX_LAST = 8'(H_RES - 1);
   localparam logic [6:0]        CY_LAST = 7'(V_RES - 1);
   localparam logic [ADDR_W-1:0] CA_LAST = ADDR_W'(H_RES * V_RES - 1);

   assign last = (ca == CA_LAST);

   // Rewind on start, otherwise advance one screen position per enabled cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cx <= '0;
         cy <= '0;
         ca <= '0;
      end else if (start) begin
         cx <= '0;
         cy <= '0;
         ca <= '0;
      end else if (en) begin
         if (cx == CX_LAST) begin
            cx <= '0;
            cy <= (cy == CY_LAST) ? '0 : cy + 7'd1;
         end else begin
            cx <= cx + 8'd1;
         end
         ca <= last ? '0 : ca + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/pixel_plotter.sv
// Turns the line drawer's per-cycle pixel stream into single-cycle
// frame-buffer writes. Repeated end-point pixels are suppressed, off-screen
// pixels are clipped and counted, and a clear FSM can sweep the whole screen.
module pixel_plotter #(
   parameter int H_RES   = 160,
   parameter int V_RES   = 120,
   parameter int COLOR_W = 3,
   parameter int ADDR_W  = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_valid,
   input  logic [8:0]         pix_x,
   input  logic [8:0]         pix_y,
   input  logic [COLOR_W-1:0] pix_colour,
   input  logic               clear_req,
   input  logic [COLOR_W-1:0] clear_colour,
   output logic               busy,
   output logic               clear_done,
   output logic               fb_we,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [7:0]         fb_x,
   output logic [6:0]         fb_y,
   output logic [COLOR_W-1:0] fb_data,
   output logic [7:0]         drop_cnt
);
   import pixel_pkg::*;

   localparam logic [8:0] X_LIM = 9'(H_RES);
   localparam logic [8:0] Y_LIM = 9'(V_RES);

   plot_state_t        state;
   plot_state_t        state_nx;
   logic [COLOR_W-1:0] clr_colour;

   pixel_t             pix_in;
   pixel_t             pix_p1;
   pixel_t             last_pix;
   logic               vld_p1;
   logic               last_vld;

   logic               in_range;
   logic               dup;
   logic               accept;
   logic               drop;

   logic               sweep_start;
   logic               sweep_en;
   logic [7:0]         sweep_x;
   logic [6:0]         sweep_y;
   logic [ADDR_W-1:0]  sweep_a;
   logic               sweep_last;

   // Discard counter saturates at all-ones instead of wrapping
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign pix_in   = '{x: pix_x[7:0], y: pix_y[6:0], colour: pix_colour};
   assign in_range = (pix_x < X_LIM) && (pix_y < Y_LIM);
   assign dup      = last_vld && (pix_in == last_pix);
   assign accept   = pix_valid && (state == IDLE) && in_range && !dup;
   assign drop     = pix_valid && ((state != IDLE) || !in_range);

   clear_sweeper #(
      .H_RES  (H_RES),
      .V_RES  (V_RES),
      .ADDR_W (ADDR_W)
   ) u_sweeper (
      .clk   (clk),
      .reset (reset),
      .start (sweep_start),
      .en    (sweep_en),
      .cx    (sweep_x),
      .cy    (sweep_y),
      .ca    (sweep_a),
      .last  (sweep_last)
   );

   // Clear FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Clear FSM next state and sweep controls; FLUSH lets an in-flight pixel drain
   always_comb begin
      state_nx    = state;
      sweep_start = 1'b0;
      sweep_en    = 1'b0;
      busy        = (state != IDLE);
      case (state)
         IDLE:    if (clear_req) state_nx = FLUSH;
         FLUSH: begin
            sweep_start = 1'b1;
            state_nx    = CLEAR;
         end
         CLEAR: begin
            sweep_en = 1'b1;
            if (sweep_last) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Fill colour is captured only when a sweep is launched
   always_ff @(posedge clk) begin
      if ((state == IDLE) && clear_req) clr_colour <= clear_colour;
   end

   // ---- S1: accept / dedupe / clip ----
   // S1 control: valid flag, last-pixel flag and discard counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1   <= 1'b0;
         last_vld <= 1'b0;
         drop_cnt <= '0;
      end else begin
         vld_p1 <= accept;
         if (state == DONE) last_vld <= 1'b0;
         else if (accept)   last_vld <= 1'b1;
         if (drop) drop_cnt <= sat_inc(drop_cnt);
      end
   end

   // S1 data: accepted pixel and the reference copy used for dedupe
   always_ff @(posedge clk) begin
      if (accept) begin
         pix_p1   <= pix_in;
         last_pix <= pix_in;
      end
   end

   // ---- S2: frame-buffer write ----
   // Sweep writes take priority; otherwise forward an accepted pixel or hold
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_x       <= '0;
         fb_y       <= '0;
         fb_data    <= '0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= (state == DONE);
         if (state == CLEAR) begin
            fb_we   <= 1'b1;
            fb_addr <= sweep_a;
            fb_x    <= sweep_x;
            fb_y    <= sweep_y;
            fb_data <= clr_colour;
         end else if (vld_p1) begin
            fb_we   <= 1'b1;
            fb_addr <= xy_to_addr(pix_p1.x, pix_p1.y);
            fb_x    <= pix_p1.x;
            fb_y    <= pix_p1.y;
            fb_data <= pix_p1.colour;
         end else begin
            fb_we   <= 1'b0;
         end
      end
   end

endmodule
